// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - ARM register file with write-back commit port and per-register in-flight scoreboard
//
// Consumer end of the WB stage: commits WB_ValueIn into R[WB_DestIn], serves two
// combinational ID read ports, tracks outstanding writes per register and stalls
// IF/ID through Hazard while a used source register still has an uncommitted write.
//
// Optional feature macro: WB_BYPASS_EN (write-through bypass of the commit value
// onto the read ports, and early Hazard release on the final retiring write).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   WB_ValueIn/WB_DestIn/WB_ENIn   write-back commit
//   Issue_EN/Issue_Dest            ID issue of an instruction that will write back
//   Src1/Src2/Src1_Valid/Two_Src   read addresses and operand-used qualifiers
//   PC_In                          PC+8, returned for reads of R15
//   Val_Rn/Val_Rm                  read data
//   Hazard                         stall request to IF/ID
//   Err_Overflow/Err_Underflow     sticky scoreboard error flags
module wb_regfile_scoreboard #(
    parameter int N     = 32,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] WB_ValueIn,
    input  logic [3:0]   WB_DestIn,
    input  logic         WB_ENIn,
    input  logic         Issue_EN,
    input  logic [3:0]   Issue_Dest,
    input  logic [3:0]   Src1,
    input  logic [3:0]   Src2,
    input  logic         Src1_Valid,
    input  logic         Two_Src,
    input  logic [N-1:0] PC_In,
    output logic [N-1:0] Val_Rn,
    output logic [N-1:0] Val_Rm,
    output logic         Hazard,
    output logic         Err_Overflow,
    output logic         Err_Underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // R15 is not stored: the PC lives in IF.
    logic [N-1:0]     regs [0:14];
    logic [CNT_W-1:0] cnt  [0:14];

    logic [15:0] busy;
    logic [14:0] inc_vec;
    logic [14:0] dec_vec;

    function automatic logic [N-1:0] read_port(input logic [3:0] addr);
        if (addr == 4'd15) begin
            return PC_In;
        end
`ifdef WB_BYPASS_EN
        if (WB_ENIn && WB_DestIn == addr) begin
            return WB_ValueIn;
        end
`endif
        return regs[addr];
    endfunction

    always_comb begin
        Val_Rn = read_port(Src1);
        Val_Rm = read_port(Src2);
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < 15; r++) begin
            busy[r] = (cnt[r] != '0);
`ifdef WB_BYPASS_EN
            // Last outstanding write retires this cycle and its value is
            // already forwarded, so the consumer need not wait.
            if (cnt[r] == CNT_ONE && WB_ENIn && WB_DestIn == 4'(r)) begin
                busy[r] = 1'b0;
            end
`endif
        end
    end

    assign Hazard = (Src1_Valid && busy[Src1]) || (Two_Src && busy[Src2]);

    // Issue is gated by Hazard so a stalled ID cannot double-count its
    // destination. Busy never depends on inc_vec, so there is no loop.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < 15; r++) begin
            inc_vec[r] = Issue_EN && !Hazard && (Issue_Dest == 4'(r));
            dec_vec[r] = WB_ENIn && (WB_DestIn == 4'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 15; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            Err_Overflow  <= 1'b0;
            Err_Underflow <= 1'b0;
        end else begin
            if (WB_ENIn && WB_DestIn != 4'd15) begin
                regs[WB_DestIn] <= WB_ValueIn;
            end
            for (int r = 0; r < 15; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (cnt[r] == CNT_MAX) begin
                        Err_Overflow <= 1'b1;
                    end else begin
                        cnt[r] <= cnt[r] + CNT_ONE;
                    end
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt[r] == '0) begin
                        Err_Underflow <= 1'b1;
                    end else begin
                        cnt[r] <= cnt[r] - CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb/tb_wb_regfile_scoreboard.sv - scoreboard bench for wb_regfile_scoreboard
module tb_wb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] WB_ValueIn;
    logic [3:0]  WB_DestIn;
    logic        WB_ENIn;
    logic        Issue_EN;
    logic [3:0]  Issue_Dest;
    logic [3:0]  Src1;
    logic [3:0]  Src2;
    logic        Src1_Valid;
    logic        Two_Src;
    logic [31:0] PC_In;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        Hazard;
    logic        Err_Overflow;
    logic        Err_Underflow;

    wb_regfile_scoreboard #(.N(32), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_ValueIn   (WB_ValueIn),
        .WB_DestIn    (WB_DestIn),
        .WB_ENIn      (WB_ENIn),
        .Issue_EN     (Issue_EN),
        .Issue_Dest   (Issue_Dest),
        .Src1         (Src1),
        .Src2         (Src2),
        .Src1_Valid   (Src1_Valid),
        .Two_Src      (Two_Src),
        .PC_In        (PC_In),
        .Val_Rn       (Val_Rn),
        .Val_Rm       (Val_Rm),
        .Hazard       (Hazard),
        .Err_Overflow (Err_Overflow),
        .Err_Underflow(Err_Underflow)
    );

    always #5 clk = ~clk;

    typedef enum int {SEL_RN, SEL_RM, SEL_HAZ, SEL_OVF, SEL_UDF} sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Stimulus drives inputs just after a rising edge and queues what the DUT
    // must show this cycle; the monitor compares on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                SEL_RN:  act = Val_Rn;
                SEL_RM:  act = Val_Rm;
                SEL_HAZ: act = {31'd0, Hazard};
                SEL_OVF: act = {31'd0, Err_Overflow};
                default: act = {31'd0, Err_Underflow};
            endcase
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input sel_t sel, input logic [31:0] v, input string name);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst        = 1'b0;
        WB_ValueIn = '0;
        WB_DestIn  = '0;
        WB_ENIn    = 1'b0;
        Issue_EN   = 1'b0;
        Issue_Dest = '0;
        Src1       = '0;
        Src2       = '0;
        Src1_Valid = 1'b0;
        Two_Src    = 1'b0;
        PC_In      = '0;
    endtask

    task automatic commit(input logic [3:0] d, input logic [31:0] v);
        WB_ENIn    = 1'b1;
        WB_DestIn  = d;
        WB_ValueIn = v;
    endtask

    task automatic issue(input logic [3:0] d);
        Issue_EN   = 1'b1;
        Issue_Dest = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();

        // Reset state on every stored register
        for (int s = 0; s < 15; s++) begin
            idle();
            Src1 = 4'(s); Src2 = 4'(14 - s); Src1_Valid = 1'b1; Two_Src = 1'b1;
            chk(SEL_RN, 32'h0, $sformatf("reset_rn_r%0d", s));
            chk(SEL_RM, 32'h0, $sformatf("reset_rm_r%0d", 14 - s));
            chk(SEL_HAZ, 32'h0, "reset_hazard");
            step();
        end
        chk(SEL_OVF, 32'h0, "reset_ovf");
        chk(SEL_UDF, 32'h0, "reset_udf");
        step();

        // Issue R3, commit 3 cycles later
        idle(); issue(4'd3); Src1 = 4'd3; Src1_Valid = 1'b1;
        chk(SEL_HAZ, 32'h0, "r3_issue_cycle_hazard");
        step();
        idle(); Src1 = 4'd3; Src1_Valid = 1'b1;
        chk(SEL_HAZ, 32'h1, "r3_busy_c1");
        step();
        chk(SEL_HAZ, 32'h1, "r3_busy_c2");
        step();
        commit(4'd3, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        chk(SEL_HAZ, 32'h0, "r3_commit_cycle_hazard");
        chk(SEL_RN, 32'hDEADBEEF, "r3_commit_cycle_bypass");
`else
        chk(SEL_HAZ, 32'h1, "r3_commit_cycle_hazard");
        chk(SEL_RN, 32'h0, "r3_commit_cycle_stored");
`endif
        step();
        idle(); Src1 = 4'd3; Src1_Valid = 1'b1;
        chk(SEL_HAZ, 32'h0, "r3_after_commit_hazard");
        chk(SEL_RN, 32'hDEADBEEF, "r3_after_commit_value");
        step();

        // Simultaneous issue and retire on R5
        idle(); issue(4'd5);
        step();
        idle(); issue(4'd5); commit(4'd5, 32'h00000055);
        chk(SEL_HAZ, 32'h0, "r5_issue_retire_hazard");
        step();
        idle(); Src2 = 4'd5; Two_Src = 1'b1;
        chk(SEL_HAZ, 32'h1, "r5_still_busy");
        chk(SEL_RM, 32'h00000055, "r5_value");
        step();
        idle(); Src2 = 4'd5; Two_Src = 1'b0;
        chk(SEL_HAZ, 32'h0, "r5_two_src_off");
        step();
        idle(); commit(4'd5, 32'h00000066);
        step();
        idle(); Src2 = 4'd5; Two_Src = 1'b1;
        chk(SEL_HAZ, 32'h0, "r5_retired");
        chk(SEL_RM, 32'h00000066, "r5_value2");
        step();

        // R7 overflow then underflow
        for (int k = 0; k < 4; k++) begin
            idle(); issue(4'd7);
            chk(SEL_OVF, 32'h0, $sformatf("r7_ovf_before_issue%0d", k));
            step();
        end
        idle(); Src1 = 4'd7; Src1_Valid = 1'b1;
        chk(SEL_OVF, 32'h1, "r7_overflow");
        chk(SEL_HAZ, 32'h1, "r7_busy_sat");
        step();
        for (int k = 0; k < 3; k++) begin
            idle(); commit(4'd7, 32'h70 + 32'(k)); Src1 = 4'd7; Src1_Valid = 1'b1;
`ifdef WB_BYPASS_EN
            chk(SEL_HAZ, (k == 2) ? 32'h0 : 32'h1, $sformatf("r7_commit%0d_hazard", k));
`else
            chk(SEL_HAZ, 32'h1, $sformatf("r7_commit%0d_hazard", k));
`endif
            step();
        end
        idle(); Src1 = 4'd7; Src1_Valid = 1'b1;
        chk(SEL_HAZ, 32'h0, "r7_cleared");
        chk(SEL_RN, 32'h72, "r7_last_value");
        chk(SEL_UDF, 32'h0, "r7_no_udf_yet");
        step();
        idle(); commit(4'd7, 32'h77);
        step();
        idle(); Src1 = 4'd7; Src1_Valid = 1'b1;
        chk(SEL_UDF, 32'h1, "r7_underflow");
        chk(SEL_RN, 32'h77, "r7_underflow_value");
        chk(SEL_OVF, 32'h1, "ovf_sticky");
        step();

        // R15 reads PC, commits to 15 dropped
        idle(); Src1 = 4'd15; Src1_Valid = 1'b1; PC_In = 32'h00000108;
        commit(4'd15, 32'hFFFFFFFF);
        chk(SEL_RN, 32'h00000108, "r15_pc");
        chk(SEL_HAZ, 32'h0, "r15_hazard");
        step();
        idle(); Src1 = 4'd3; Src2 = 4'd0;
        chk(SEL_RN, 32'hDEADBEEF, "r3_kept_after_r15");
        chk(SEL_RM, 32'h0, "r0_kept_after_r15");
        step();
        idle(); Src1 = 4'd5; Src2 = 4'd14;
        chk(SEL_RN, 32'h66, "r5_kept_after_r15");
        chk(SEL_RM, 32'h0, "r14_kept_after_r15");
        step();

        // Reset beats pending commit with cnt[2]=2
        idle(); issue(4'd2);
        step();
        idle(); issue(4'd2);
        step();
        idle(); rst = 1'b1; commit(4'd2, 32'h22222222); Src1 = 4'd2; Src1_Valid = 1'b1;
        chk(SEL_HAZ, 32'h1, "r2_busy_at_reset");
        step();
        idle(); Src1 = 4'd2; Src1_Valid = 1'b1; Src2 = 4'd3; Two_Src = 1'b1;
        chk(SEL_HAZ, 32'h0, "r2_hazard_after_reset");
        chk(SEL_RN, 32'h0, "r2_zero_after_reset");
        chk(SEL_RM, 32'h0, "r3_zero_after_reset");
        chk(SEL_OVF, 32'h0, "ovf_cleared");
        chk(SEL_UDF, 32'h0, "udf_cleared");
        step();
        idle();

        // Monitor should drain the queue within a cycle; bound the wait.
        for (int t = 0; t < 4 && exp_q.size() > 0; t++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
